// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package stream_demux_pkg;

    localparam int DROP_CNT_W = 8;

    // Select width for a given channel count; at least one bit.
    function automatic int sel_width(input int nch);
        return (nch < 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             m_ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             free
);

    // A full slot being drained this cycle can accept a new word at the same edge.
    assign free = ~valid | m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (m_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each input word to one channel slot, to all
// slots (broadcast), or discards and counts it when the select is out of range.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = sel_width(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic [SELW-1:0]       s_sel,
    input  logic                  s_bcast,
    output logic [NCH-1:0]        m_valid,
    input  logic [NCH-1:0]        m_ready,
    output logic [NCH*WIDTH-1:0]  m_data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  drop_pulse
);

    logic [NCH-1:0] sel_hit;
    logic [NCH-1:0] slot_free;
    logic [NCH-1:0] slot_load;
    logic           sel_legal;
    logic           xfer;
    logic           drop;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // s_ready is built from select, broadcast and slot state only, never s_valid.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NCH; k++) begin
            sel_hit[k] = (s_sel == SELW'(k));
        end
        sel_legal = |sel_hit;

        if (s_bcast) begin
            s_ready = &slot_free;
        end else if (sel_legal) begin
            s_ready = |(sel_hit & slot_free);
        end else begin
            s_ready = 1'b1;
        end

        xfer      = s_valid & s_ready;
        slot_load = '0;
        if (xfer) begin
            slot_load = s_bcast ? {NCH{1'b1}} : sel_hit;
        end
        drop = xfer & ~s_bcast & ~sel_legal;
    end

    // Held low during reset so the flag matches the cleared counter.
    assign drop_pulse = drop & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (slot_load[k]),
            .din     (s_data),
            .m_ready (m_ready[k]),
            .valid   (m_valid[k]),
            .dout    (m_data[k*WIDTH +: WIDTH]),
            .free    (slot_free[k])
        );
    end

endmodule
